// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared types and constants for the pipeline hazard controller.
// Rev    : 1.0  initial release
// ============================================================================
package pipe_pkg;

    // Widest register-address field a stage tag can hold; narrower RA_W is zero-extended.
    localparam int RA_MAX      = 8;
    localparam int FWD_RF      = 0;
    localparam int ALU_RDY_DEF = 1;
    localparam int LD_RDY_DEF  = 2;

    typedef struct packed {
        logic              valid;
        logic [RA_MAX-1:0] rd;
        logic              regwrite;
        logic              load;
    } stage_tag_t;

    localparam stage_tag_t TAG_NONE = '0;

    function automatic logic tag_match(input stage_tag_t t,
                                       input logic [RA_MAX-1:0] src,
                                       input logic use_src);
        return use_src && t.valid && t.regwrite && (t.rd != '0) && (t.rd == src);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : pipe_hazard_ctrl_if
// Brief  : ID-stage decode inputs and hazard/forwarding outputs.
// Rev    : 1.0  initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int RA_W  = 5,
    parameter int NPOST = 3,
    parameter int CNT_W = 32
);
    localparam int FW = (NPOST > 1) ? $clog2(NPOST) : 1;

    logic            freeze;
    logic            cnt_clr;
    logic            id_valid;
    logic            id_use_rs;
    logic            id_use_rt;
    logic            id_branch;
    logic            id_jump;
    logic            br_taken;
    logic            id_regwrite;
    logic            id_load;
    logic [RA_W-1:0] id_rs;
    logic [RA_W-1:0] id_rt;
    logic [RA_W-1:0] id_rd;

    logic             stall;
    logic             bubble_ex;
    logic             flush_ifid;
    logic [FW-1:0]    fwd_id_rs;
    logic [FW-1:0]    fwd_id_rt;
    logic [FW-1:0]    fwd_ex_rs;
    logic [FW-1:0]    fwd_ex_rt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output freeze, cnt_clr, id_valid, id_use_rs, id_use_rt, id_branch, id_jump,
               br_taken, id_regwrite, id_load, id_rs, id_rt, id_rd,
        input  stall, bubble_ex, flush_ifid, fwd_id_rs, fwd_id_rt, fwd_ex_rs, fwd_ex_rt,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  freeze, cnt_clr, id_valid, id_use_rs, id_use_rt, id_branch, id_jump,
               br_taken, id_regwrite, id_load, id_rs, id_rt, id_rd,
        output stall, bubble_ex, flush_ifid, fwd_id_rs, fwd_id_rt, fwd_ex_rs, fwd_ex_rt,
               stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_tag.sv
`default_nettype none
// ============================================================================
// Module : pipe_stage_tag
// Brief  : One post-ID stage tag register with hold enable.
// Rev    : 1.0  initial release
// ============================================================================
module pipe_stage_tag
    import pipe_pkg::*;
(
    input  wire        clk,
    input  wire        rst,
    input  wire        i_en,
    input  stage_tag_t i_d,
    output stage_tag_t o_q
);

    stage_tag_t r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= TAG_NONE;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pipe_hazard_ctrl
// Brief  : Stall/bubble/flush and forwarding-select control for an in-order pipe.
// Rev    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int RA_W    = 5,
    parameter int NPOST   = 3,
    parameter int ALU_RDY = ALU_RDY_DEF,
    parameter int LD_RDY  = LD_RDY_DEF,
    parameter int CNT_W   = 32
)(
    input wire                clk,
    input wire                rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int FW = (NPOST > 1) ? $clog2(NPOST) : 1;

    stage_tag_t [NPOST-1:0] w_tag_d;
    stage_tag_t [NPOST-1:0] w_tag_q;

    logic [RA_MAX-1:0] w_id_rs;
    logic [RA_MAX-1:0] w_id_rt;
    logic [RA_MAX-1:0] w_id_rd;
    logic [RA_MAX-1:0] r_ex_rs;
    logic [RA_MAX-1:0] r_ex_rt;
    logic              r_ex_use_rs;
    logic              r_ex_use_rt;

    logic          w_adv;
    logic          w_haz_rs;
    logic          w_haz_rt;
    logic          w_haz_stall;
    logic          w_stall;
    logic          w_bubble;
    logic          w_flush;
    logic [FW-1:0] w_fid_rs;
    logic [FW-1:0] w_fid_rt;
    logic [FW-1:0] w_fex_rs;
    logic [FW-1:0] w_fex_rt;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Youngest match decides both the hazard and the forward source; a branch
    // resolves in ID so it needs the value one cycle earlier than an EX consumer.
    function automatic logic [FW:0] scan_id(input stage_tag_t [NPOST-1:0] tags,
                                            input logic [RA_MAX-1:0] src,
                                            input logic use_src,
                                            input logic branch);
        logic          hit;
        int            k_hit;
        int            rdy;
        logic          haz;
        logic [FW-1:0] fwd;
        hit   = 1'b0;
        k_hit = 0;
        rdy   = ALU_RDY;
        for (int k = NPOST - 1; k >= 0; k--) begin
            if (tag_match(tags[k], src, use_src)) begin
                hit   = 1'b1;
                k_hit = k;
                rdy   = tags[k].load ? LD_RDY : ALU_RDY;
            end
        end
        haz = hit && (branch ? (k_hit < rdy) : (k_hit + 1 < rdy));
        fwd = (hit && (k_hit >= 1) && (k_hit >= rdy)) ? FW'(k_hit) : FW'(FWD_RF);
        return {haz, fwd};
    endfunction

    function automatic logic [FW-1:0] scan_ex(input stage_tag_t [NPOST-1:0] tags,
                                              input logic [RA_MAX-1:0] src,
                                              input logic use_src);
        logic [FW-1:0] fwd;
        fwd = FW'(FWD_RF);
        for (int k = NPOST - 1; k >= 1; k--) begin
            if (tag_match(tags[k], src, use_src)) begin
                fwd = FW'(k);
            end
        end
        return fwd;
    endfunction

    always_comb begin
        w_id_rs = '0;
        w_id_rt = '0;
        w_id_rd = '0;
        w_id_rs[RA_W-1:0] = bus.id_rs;
        w_id_rt[RA_W-1:0] = bus.id_rt;
        w_id_rd[RA_W-1:0] = bus.id_rd;
    end

    always_comb begin
        {w_haz_rs, w_fid_rs} = scan_id(w_tag_q, w_id_rs, bus.id_use_rs, bus.id_branch);
        {w_haz_rt, w_fid_rt} = scan_id(w_tag_q, w_id_rt, bus.id_use_rt, bus.id_branch);
        w_fex_rs = scan_ex(w_tag_q, r_ex_rs, r_ex_use_rs);
        w_fex_rt = scan_ex(w_tag_q, r_ex_rt, r_ex_use_rt);
    end

    // Reset gating keeps freeze/decode inputs from leaking onto the outputs while rst is high.
    assign w_adv       = !bus.freeze;
    assign w_haz_stall = bus.id_valid && (w_haz_rs || w_haz_rt);
    assign w_stall     = !rst && (bus.freeze || w_haz_stall);
    assign w_bubble    = !rst && !bus.freeze && w_haz_stall;
    assign w_flush     = !rst && bus.id_valid && !w_stall &&
                         (bus.id_jump || (bus.id_branch && bus.br_taken));

    always_comb begin
        w_tag_d = '0;
        if (!w_bubble) begin
            w_tag_d[0].valid    = bus.id_valid;
            w_tag_d[0].rd       = w_id_rd;
            w_tag_d[0].regwrite = bus.id_regwrite;
            w_tag_d[0].load     = bus.id_load;
        end
        for (int k = 1; k < NPOST; k++) begin
            w_tag_d[k] = w_tag_q[k-1];
        end
    end

    for (genvar k = 0; k < NPOST; k++) begin : g_stage
        pipe_stage_tag u_tag (
            .clk  (clk),
            .rst  (rst),
            .i_en (w_adv),
            .i_d  (w_tag_d[k]),
            .o_q  (w_tag_q[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_rs     <= '0;
            r_ex_rt     <= '0;
            r_ex_use_rs <= 1'b0;
            r_ex_use_rt <= 1'b0;
        end else if (w_adv) begin
            r_ex_rs     <= w_id_rs;
            r_ex_rt     <= w_id_rt;
            r_ex_use_rs <= bus.id_valid && !w_bubble && bus.id_use_rs;
            r_ex_use_rt <= bus.id_valid && !w_bubble && bus.id_use_rt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_bubble && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign bus.stall      = w_stall;
    assign bus.bubble_ex  = w_bubble;
    assign bus.flush_ifid = w_flush;
    assign bus.fwd_id_rs  = w_fid_rs;
    assign bus.fwd_id_rt  = w_fid_rt;
    assign bus.fwd_ex_rs  = w_fex_rs;
    assign bus.fwd_ex_rt  = w_fex_rt;
    assign bus.stall_cnt  = r_stall_cnt;
    assign bus.flush_cnt  = r_flush_cnt;

endmodule
`default_nettype wire
